// File: rtl/trace_write_scheduler.sv
// trace_write_scheduler: per-channel FIFOs feeding one trace-memory write port, round-robin, blanking-only writes.
// Define TRACE_CLEAR_EN to add the clear_req/clear_busy midscale clear sequence.
module trace_write_scheduler #(
    parameter int          FIFO_DEPTH = 4,
    parameter int          TRACE_LEN  = 800,
    parameter logic [11:0] ECG_BASE   = 12'h801,
    parameter logic [11:0] EMG_BASE   = 12'h4E1
) (
    input  logic        clock,
    input  logic        reset,
`ifdef TRACE_CLEAR_EN
    input  logic        clear_req,
    output logic        clear_busy,
`endif
    input  logic        ecg_valid,
    input  logic [11:0] ecg_data,
    output logic        ecg_ready,
    input  logic        emg_valid,
    input  logic [11:0] emg_data,
    output logic        emg_ready,
    input  logic        vga_active,
    output logic        mem_we,
    output logic [11:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [9:0]  ecg_wptr,
    output logic [9:0]  emg_wptr
);
    localparam int         AW   = $clog2(FIFO_DEPTH);
    localparam logic [9:0] LAST = 10'(TRACE_LEN - 1);
    localparam logic [AW:0] ONE = {{AW{1'b0}}, 1'b1};

    // channel index 0 is ECG, 1 is EMG
    logic [11:0] buf_q [2][FIFO_DEPTH];
    logic [11:0] buf_d [2][FIFO_DEPTH];
    logic [AW:0] wr_q [2];
    logic [AW:0] wr_d [2];
    logic [AW:0] rd_q [2];
    logic [AW:0] rd_d [2];
    logic [9:0]  wptr_q [2];
    logic [9:0]  wptr_d [2];
    logic        prio_q, prio_d;
    logic [11:0] addr_q, addr_d;
    logic [11:0] wdata_q, wdata_d;
    logic [1:0]  valid, full, nempty;
    logic [11:0] din [2];
    logic        busy, sel, gnt;
    logic        clear_write, clear_done;
    logic [11:0] clr_addr;

`ifdef TRACE_CLEAR_EN
    typedef enum logic {IDLE, CLEAR} state_t;
    state_t      state_q, state_d;
    logic [10:0] idx_q, idx_d;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        clear_write = (state_q == CLEAR) && !vga_active;
        clear_done  = clear_write && (idx_q == 11'(2 * TRACE_LEN - 1));
        if (state_q == IDLE && clear_req) state_d = CLEAR;
        if (clear_write) idx_d = clear_done ? '0 : idx_q + 11'd1;
        if (clear_done) state_d = IDLE;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    assign busy       = (state_q == CLEAR);
    assign clear_busy = busy;
    assign clr_addr   = EMG_BASE + {1'b0, idx_q};
`else
    assign busy        = 1'b0;
    assign clear_write = 1'b0;
    assign clear_done  = 1'b0;
    assign clr_addr    = '0;
`endif

    always_comb begin
        valid  = {emg_valid, ecg_valid};
        din[0] = ecg_data;
        din[1] = emg_data;
        buf_d  = buf_q;
        wr_d   = wr_q;
        rd_d   = rd_q;
        wptr_d = wptr_q;
        prio_d = prio_q;
        for (int c = 0; c < 2; c++) begin
            full[c]   = (wr_q[c][AW] != rd_q[c][AW]) && (wr_q[c][AW-1:0] == rd_q[c][AW-1:0]);
            nempty[c] = (wr_q[c] != rd_q[c]);
            if (valid[c] && !full[c] && !busy) begin
                buf_d[c][wr_q[c][AW-1:0]] = din[c];
                wr_d[c] = wr_q[c] + ONE;
            end
        end
        gnt       = !vga_active && !busy && (nempty != 2'b00);
        sel       = nempty[1] && (!nempty[0] || prio_q);
        mem_we    = gnt || clear_write;
        mem_addr  = addr_q;
        mem_wdata = {20'b0, wdata_q};
        if (gnt) begin
            mem_addr     = (sel ? EMG_BASE : ECG_BASE) + {2'b0, wptr_q[sel]};
            mem_wdata    = {20'b0, buf_q[sel][rd_q[sel][AW-1:0]]};
            rd_d[sel]    = rd_q[sel] + ONE;
            wptr_d[sel]  = (wptr_q[sel] == LAST) ? '0 : wptr_q[sel] + 10'd1;
            prio_d       = !sel;
        end
        if (clear_write) begin
            mem_addr  = clr_addr;
            mem_wdata = 32'h800;
        end
        if (clear_done) begin
            wptr_d[0] = '0;
            wptr_d[1] = '0;
        end
        addr_d  = mem_addr;
        wdata_d = mem_wdata[11:0];
    end

    always_ff @(posedge clock) buf_q <= buf_d;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int c = 0; c < 2; c++) begin
                wr_q[c]   <= '0;
                rd_q[c]   <= '0;
                wptr_q[c] <= '0;
            end
            prio_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            wptr_q  <= wptr_d;
            prio_q  <= prio_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign ecg_ready = !full[0] && !busy;
    assign emg_ready = !full[1] && !busy;
    assign ecg_wptr  = wptr_q[0];
    assign emg_wptr  = wptr_q[1];
endmodule

// File: tb/tb_trace_write_scheduler.sv
// tb_trace_write_scheduler: vector table plus scoreboard of per-channel expected writes.
module tb_trace_write_scheduler;
    localparam logic [11:0] ECG_BASE = 12'h801;
    localparam logic [11:0] EMG_BASE = 12'h4E1;

    logic        clk = 0, rst_n = 0;
    logic        ecg_valid = 0, emg_valid = 0, vga_active = 0;
    logic [11:0] ecg_data = 0, emg_data = 0;
    logic        ecg_ready, emg_ready, mem_we;
    logic [11:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [9:0]  ecg_wptr, emg_wptr;
`ifdef TRACE_CLEAR_EN
    logic        clear_req = 0;
    logic        clear_busy;
`endif

    trace_write_scheduler dut (
        .clock(clk), .reset(rst_n),
`ifdef TRACE_CLEAR_EN
        .clear_req(clear_req), .clear_busy(clear_busy),
`endif
        .ecg_valid(ecg_valid), .ecg_data(ecg_data), .ecg_ready(ecg_ready),
        .emg_valid(emg_valid), .emg_data(emg_data), .emg_ready(emg_ready),
        .vga_active(vga_active), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .ecg_wptr(ecg_wptr), .emg_wptr(emg_wptr)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;
    logic [43:0] ecg_q [$];
    logic [43:0] emg_q [$];
    logic        chan_log [$];
    int ecg_mp = 0, emg_mp = 0, acc_ecg = 0, acc_emg = 0, wr_cnt = 0, vga_writes = 0;
    int clr_cnt = 0, clr_bad = 0;
    logic log_en = 0, in_clear = 0, is_ecg;
    logic [43:0] exp_w;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Writes are checked against per-channel queues; accepted samples are queued with their model address.
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_we && vga_active) vga_writes++;
            if (mem_we && in_clear) begin
                if (mem_addr != EMG_BASE + 12'(clr_cnt) || mem_wdata != 32'h800) clr_bad++;
                clr_cnt++;
            end else if (mem_we) begin
                wr_cnt++;
                is_ecg = (mem_addr >= ECG_BASE);
                if (log_en) chan_log.push_back(is_ecg);
                exp_w = '1;
                if (is_ecg && ecg_q.size() != 0) exp_w = ecg_q.pop_front();
                if (!is_ecg && emg_q.size() != 0) exp_w = emg_q.pop_front();
                chk(is_ecg ? "ecg_write" : "emg_write", {mem_addr, mem_wdata}, exp_w);
            end
            if (ecg_valid && ecg_ready) begin
                ecg_q.push_back({ECG_BASE + 12'(ecg_mp), 20'b0, ecg_data});
                ecg_mp = (ecg_mp == 799) ? 0 : ecg_mp + 1;
                acc_ecg++;
            end
            if (emg_valid && emg_ready) begin
                emg_q.push_back({EMG_BASE + 12'(emg_mp), 20'b0, emg_data});
                emg_mp = (emg_mp == 799) ? 0 : emg_mp + 1;
                acc_emg++;
            end
        end
    end

    typedef struct {
        logic ev; logic [11:0] ed; logic mv; logic [11:0] md; logic vga;
        logic we; logic [11:0] addr; logic [11:0] wd; logic er; logic mr;
        logic [9:0] ewp; logic [9:0] mwp;
    } vec_t;
    vec_t tbl [9];

    task automatic wait_drain();
        int n = 0;
        while ((ecg_q.size() != 0 || emg_q.size() != 0) && n < 100) begin
            @(posedge clk); #2; n++;
        end
        chk("drain_pending", 64'(ecg_q.size() + emg_q.size()), 0);
    endtask

    task automatic one_ecg(input logic [11:0] d, input logic [11:0] exp_addr, input string name);
        @(posedge clk); #1 ecg_valid = 1; ecg_data = d;
        @(posedge clk); #1 ecg_valid = 0;
        @(negedge clk); #1;
        chk({name, "_we"}, mem_we, 1);
        chk({name, "_addr"}, mem_addr, exp_addr);
    endtask

    initial begin
        int alt_bad;
        //          ev ed      mv md      vga we addr     wd      er mr ewp mwp
        tbl[0] = '{1, 12'h123, 0, 12'h000, 0, 0, 12'h000, 12'h000, 1, 1, 0, 0};
        tbl[1] = '{0, 12'h000, 0, 12'h000, 0, 1, 12'h801, 12'h123, 1, 1, 0, 0};
        tbl[2] = '{0, 12'h000, 0, 12'h000, 0, 0, 12'h801, 12'h123, 1, 1, 1, 0};
        tbl[3] = '{1, 12'h124, 1, 12'h456, 0, 0, 12'h801, 12'h123, 1, 1, 1, 0};
        tbl[4] = '{0, 12'h000, 0, 12'h000, 0, 1, 12'h4E1, 12'h456, 1, 1, 1, 0};
        tbl[5] = '{0, 12'h000, 0, 12'h000, 0, 1, 12'h802, 12'h124, 1, 1, 1, 1};
        tbl[6] = '{1, 12'h200, 0, 12'h000, 1, 0, 12'h802, 12'h124, 1, 1, 2, 1};
        tbl[7] = '{0, 12'h000, 0, 12'h000, 1, 0, 12'h802, 12'h124, 1, 1, 2, 1};
        tbl[8] = '{0, 12'h000, 0, 12'h000, 0, 1, 12'h803, 12'h200, 1, 1, 2, 1};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_we", mem_we, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_ready", {ecg_ready, emg_ready}, 2'b11);
        chk("rst_wptr", {ecg_wptr, emg_wptr}, 0);
        @(posedge clk); #1 rst_n = 1;

        foreach (tbl[i]) begin
            @(posedge clk); #1;
            ecg_valid = tbl[i].ev; ecg_data = tbl[i].ed;
            emg_valid = tbl[i].mv; emg_data = tbl[i].md;
            vga_active = tbl[i].vga;
            @(negedge clk); #1;
            chk($sformatf("v%0d_we", i), mem_we, tbl[i].we);
            chk($sformatf("v%0d_addr", i), mem_addr, tbl[i].addr);
            chk($sformatf("v%0d_wdata", i), mem_wdata, {20'b0, tbl[i].wd});
            chk($sformatf("v%0d_ready", i), {ecg_ready, emg_ready}, {tbl[i].er, tbl[i].mr});
            chk($sformatf("v%0d_wptr", i), {ecg_wptr, emg_wptr}, {tbl[i].ewp, tbl[i].mwp});
        end
        @(posedge clk); #1 ecg_valid = 0; emg_valid = 0; vga_active = 0;
        wait_drain();

        log_en = 1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            ecg_valid = 1; emg_valid = 1;
            ecg_data = 12'($urandom); emg_data = 12'($urandom);
        end
        @(posedge clk); #1 ecg_valid = 0; emg_valid = 0; log_en = 0;
        wait_drain();
        alt_bad = 0;
        for (int i = 1; i < chan_log.size(); i++) if (chan_log[i] == chan_log[i-1]) alt_bad++;
        chk("rr_alternate", 64'(alt_bad), 0);
        chk("rr_count_ok", 64'(chan_log.size() >= 10), 1);

        acc_ecg = 0; acc_emg = 0; vga_writes = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            vga_active = 1; ecg_valid = 1; emg_valid = 1;
            ecg_data = 12'($urandom); emg_data = 12'($urandom);
        end
        @(negedge clk);
        chk("bp_ready", {ecg_ready, emg_ready}, 2'b00);
        chk("bp_we", mem_we, 0);
        @(posedge clk); #1 ecg_valid = 0; emg_valid = 0;
        chk("bp_acc_ecg", 64'(acc_ecg), 4);
        chk("bp_acc_emg", 64'(acc_emg), 4);
        chk("bp_vga_writes", 64'(vga_writes), 0);
        wr_cnt = 0; vga_active = 0;
        wait_drain();
        chk("bp_drain_writes", 64'(wr_cnt), 8);

        for (int i = 0; i < 1000; i++) begin
            @(posedge clk); #1;
            if (ecg_mp == 799) break;
            ecg_valid = 1; ecg_data = 12'($urandom);
        end
        ecg_valid = 0;
        wait_drain();
        chk("wrap_pre_wptr", ecg_wptr, 799);
        one_ecg(12'h5A5, 12'hB20, "wrap_last");
        @(posedge clk); #1 chk("wrap_wptr", ecg_wptr, 0);
        one_ecg(12'h3C3, 12'h801, "wrap_first");
        wait_drain();

`ifdef TRACE_CLEAR_EN
        @(posedge clk); #1 clear_req = 1; in_clear = 1;
        @(posedge clk); #1 clear_req = 0; vga_active = 1;
        chk("clr_busy", clear_busy, 1);
        chk("clr_ready", {ecg_ready, emg_ready}, 2'b00);
        for (int i = 0; i < 2000 && clear_busy; i++) begin
            @(posedge clk); #1;
            if (i == 10) vga_active = 0;
        end
        chk("clr_done", clear_busy, 0);
        chk("clr_count", 64'(clr_cnt), 1600);
        chk("clr_bad", 64'(clr_bad), 0);
        chk("clr_wptr", {ecg_wptr, emg_wptr}, 0);
        chk("clr_ready_back", {ecg_ready, emg_ready}, 2'b11);
        chk("clr_vga_writes", 64'(vga_writes), 0);
        in_clear = 0; ecg_mp = 0; emg_mp = 0;
`endif

        @(posedge clk); #1 ecg_valid = 1; ecg_data = 12'h777;
        @(posedge clk); #1 ecg_valid = 0;
        @(negedge clk); #1 chk("rstw_we_before", mem_we, 1);
        #2 rst_n = 0;
        #1 chk("rstw_we_async", mem_we, 0);
        ecg_q.delete(); emg_q.delete(); ecg_mp = 0; emg_mp = 0;
        @(negedge clk);
        chk("rstw_we_next", mem_we, 0);
        chk("rstw_addr", mem_addr, 0);
        chk("rstw_ready", {ecg_ready, emg_ready}, 2'b11);
        chk("rstw_wptr", {ecg_wptr, emg_wptr}, 0);
        @(posedge clk); #1 rst_n = 1;
        repeat (2) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/trace_write_scheduler.md
Name: trace_write_scheduler

Overview:
- Shares the single write port of the signal trace memory between two sample producers: the ECG and EMG acquisition paths.
- The VGA display reads the same memory during active video, so writes are issued only while the display is blanking.
- Each channel is buffered in a small FIFO, the two channels are arbitrated round-robin, and each channel has a circular write pointer.
- The circular pointers are exported so that the display can scroll its traces.

Parameters:
- FIFO_DEPTH, 4, entries per channel FIFO (power of 2, minimum 2).
- TRACE_LEN, 800, samples per channel trace (one per display column).
- ECG_BASE, 12'h801, memory word address of ECG sample 0.
- EMG_BASE, 12'h4E1, memory word address of EMG sample 0. The EMG and ECG regions are contiguous and must not overlap.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous reset, active-low (asserted when 0).
- ecg_valid  in  1  ECG sample offered.
- ecg_data  in  12  ECG sample.
- ecg_ready  out  1  ECG FIFO can accept.
- emg_valid  in  1  EMG sample offered.
- emg_data  in  12  EMG sample.
- emg_ready  out  1  EMG FIFO can accept.
- vga_active  in  1  display in active video; memory port owned by the reader.
- mem_we  out  1  write strobe to trace memory.
- mem_addr  out  12  write word address.
- mem_wdata  out  32  write data, {20'b0, sample}.
- ecg_wptr  out  10  next ECG write index, 0..TRACE_LEN-1.
- emg_wptr  out  10  next EMG write index, 0..TRACE_LEN-1.

Behaviour:
- Reset (reset==0, asynchronous):
  - FIFOs empty; pointers 0; round-robin priority set to ECG first.
  - Outputs: mem_we=0, mem_addr=0, mem_wdata=0, ecg_ready=emg_ready=1 (in CLEAR_EN build, ready=0 while clear_busy=1).
  - Reset mid-write: the write is aborted, and no strobe appears in the next cycle.
- Input handshake:
  - A sample is accepted on a rising edge where valid && ready.
  - ready = !full, combinational from FIFO state only; it never depends on valid.
  - An accepted sample is at the FIFO head the following cycle.
  - Simultaneous push and pop on a full FIFO is not allowed (ready is 0). On a non-empty, non-full FIFO, a simultaneous push and pop leaves the count unchanged.
- Write grant (combinational, same cycle):
  - grant possible when vga_active==0 and at least one FIFO is non-empty.
  - If only one FIFO is non-empty, that channel is granted.
  - If both are non-empty, the channel not granted last is granted; the priority flag updates on each grant.
- Granted cycle outputs:
  - mem_we=1.
  - mem_addr = BASE + wptr, 12-bit.
  - mem_wdata = {20'b0, head}.
  - The head is popped, and wptr increments on the clock edge.
  - Pointer wrap: wptr==TRACE_LEN-1 goes to 0.
- No write condition: when vga_active==1 or both FIFOs are empty, mem_we=0, and mem_addr and mem_wdata are held at their last values.
- Throughput: at most one memory write per cycle in total. Minimum latency from input acceptance to mem_we is 1 cycle.
- Back-pressure: with vga_active held high, each FIFO fills and its ready drops after FIFO_DEPTH accepts. No sample is ever dropped or overwritten.

Optional Feature:
- Macro TRACE_CLEAR_EN.
- When defined, the block adds:
  - input clear_req (1), a pulse.
  - output clear_busy (1).
- Clear sequence:
  - clear_req while idle enters state CLEAR, and clear_busy=1 the next cycle.
  - In CLEAR, a 11-bit index runs 0..2*TRACE_LEN-1 and writes 12'h800 (midscale) to EMG_BASE+idx, covering both contiguous regions.
  - Writes occur only when vga_active==0, one per cycle.
  - Both ready outputs are held 0, but FIFO contents are kept.
  - After the last write: pointers are set to 0, the state returns to IDLE, and clear_busy=0.
  - clear_req during CLEAR is ignored.
- When undefined, the ports are absent and the block is always in normal scheduling.

Test Plan:
1. Reset release, vga_active=0, one ECG sample 12'h123 -> next cycle mem_we=1, mem_addr=12'h801, mem_wdata=32'h123, ecg_wptr becomes 1.
2. ECG and EMG valid every cycle, vga_active=0 -> writes alternate ECG, EMG, ECG, and so on. EMG addresses run 12'h4E1, 12'h4E2, ...
3. vga_active=1 for 20 cycles with both valid -> mem_we stays 0. Each ready drops after 4 accepts. On blanking, 8 writes drain in FIFO order with none lost.
4. 800 ECG samples then one more -> 800th write to 12'hB20. The 801st write goes to 12'h801, with ecg_wptr 799->0.
5. Sample accepted in the same cycle vga_active rises -> no write until vga_active falls. The write then occurs with the correct data.
6. (TRACE_CLEAR_EN) clear_req with vga_active=0 -> 1600 writes of 32'h800 from 12'h4E1 to 12'hB20. Then clear_busy=0, both wptr=0, and ready returns high.
